parallel_lane_packer: RTL and testbench

- Upstream feeder for the parallel accumulator.
- Accepts a serial stream of DATA_WIDTH samples over a valid/ready handshake and packs them into PAR_FACTOR lanes.
- Presents each completed lane group with a one-cycle en pulse, which drives the accumulator's data_in array and en directly.
- Double-buffered (fill buffer plus output register) so the serial input can run at one sample per cycle while a group waits for downstream.

---
 rtl/parallel_lane_packer.sv | 110 +++++++++++
 tb/tb_parallel_lane_packer.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/parallel_lane_packer.sv
// Serial-to-parallel lane packer: fills PAR_FACTOR lanes from a valid/ready stream and
// holds each group in an output register until downstream takes it. Optional PACKER_GRP_CNT_EN.
module parallel_lane_packer #(
  parameter int PAR_FACTOR = 4,
  parameter int DATA_WIDTH = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] s_data,
  input  logic                  s_valid,
  output logic                  s_ready,
  input  logic                  s_last,
  output logic [DATA_WIDTH-1:0] data_out [PAR_FACTOR],
  output logic [PAR_FACTOR-1:0] lane_mask,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic                  en
`ifdef PACKER_GRP_CNT_EN
  ,
  output logic [15:0]           grp_cnt,
  output logic                  short_grp
`endif
);

  localparam int IW = $clog2(PAR_FACTOR);
  localparam logic [IW-1:0] LAST = IW'(PAR_FACTOR - 1);

  typedef enum logic {S_FILL, S_WAIT} state_t;

  state_t                state, state_nxt;
  logic                  rdy_q;
  logic [IW-1:0]         idx;
  logic [DATA_WIDTH-1:0] fill_buf [PAR_FACTOR];
  logic [PAR_FACTOR-1:0] fill_mask, lane_hit;
  logic                  accept, close, out_free, ld_direct, ld_wait;

  // rdy_q keeps s_ready low until the first edge after reset release
  assign s_ready   = rdy_q & (state == S_FILL);
  assign accept    = s_valid & s_ready;
  assign close     = accept & (s_last | (idx == LAST));
  assign out_free  = ~m_valid | m_ready;
  assign en        = m_valid & m_ready;
  assign ld_direct = close & out_free;
  assign ld_wait   = (state == S_WAIT) & m_ready;

  for (genvar i = 0; i < PAR_FACTOR; i++) begin : g_hit
    assign lane_hit[i] = accept & (idx == IW'(i));
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= S_FILL;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_FILL:  if (close & ~out_free) state_nxt = S_WAIT;
      S_WAIT:  if (m_ready)           state_nxt = S_FILL;
      default: state_nxt = S_FILL;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rdy_q   <= 1'b0;
      idx     <= '0;
      m_valid <= 1'b0;
    end else begin
      rdy_q <= 1'b1;
      if (close)       idx <= '0;
      else if (accept) idx <= idx + IW'(1);
      if (ld_direct | ld_wait) m_valid <= 1'b1;
      else if (m_ready)        m_valid <= 1'b0;
    end
  end

  // A direct load merges the closing sample in flight; lanes past it are already zero
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < PAR_FACTOR; i++) begin
        fill_buf[i] <= '0;
        data_out[i] <= '0;
      end
      fill_mask <= '0;
      lane_mask <= '0;
    end else begin
      for (int i = 0; i < PAR_FACTOR; i++) begin
        if (ld_direct)    data_out[i] <= lane_hit[i] ? s_data : fill_buf[i];
        else if (ld_wait) data_out[i] <= fill_buf[i];
        if (ld_direct | ld_wait) fill_buf[i] <= '0;
        else if (lane_hit[i])    fill_buf[i] <= s_data;
      end
      if (ld_direct)    lane_mask <= fill_mask | lane_hit;
      else if (ld_wait) lane_mask <= fill_mask;
      if (ld_direct | ld_wait) fill_mask <= '0;
      else                     fill_mask <= fill_mask | lane_hit;
    end
  end

`ifdef PACKER_GRP_CNT_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)    grp_cnt <= '0;
    else if (en) grp_cnt <= grp_cnt + 16'd1;
  end

  assign short_grp = m_valid & ~&lane_mask;
`endif

endmodule

// File: tb/tb_parallel_lane_packer.sv
// Bench for parallel_lane_packer: a queue-based model of closed-but-undelivered groups
// is checked every cycle, plus directed sequences pinned with literal groups.
module tb_parallel_lane_packer;
  localparam int P  = 4;
  localparam int DW = 4;
  localparam int GW = P * DW;

  logic          clk, rst;
  logic [DW-1:0] s_data;
  logic          s_valid, s_ready, s_last;
  logic [DW-1:0] data_out [P];
  logic [P-1:0]  lane_mask;
  logic          m_valid, m_ready, en;
`ifdef PACKER_GRP_CNT_EN
  logic [15:0]   grp_cnt;
  logic          short_grp;
`endif

  parallel_lane_packer #(.PAR_FACTOR(P), .DATA_WIDTH(DW)) dut (
    .clk(clk), .rst(rst), .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
    .s_last(s_last), .data_out(data_out), .lane_mask(lane_mask), .m_valid(m_valid),
    .m_ready(m_ready), .en(en)
`ifdef PACKER_GRP_CNT_EN
    , .grp_cnt(grp_cnt), .short_grp(short_grp)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int nvec = 0, nerr = 0, stalls = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  logic [GW-1:0] flat;
  always_comb begin
    flat = '0;
    for (int i = 0; i < P; i++) flat[i*DW +: DW] = data_out[i];
  end

  // Model: queue of groups closed but not yet delivered (head = what the output must show)
  logic [GW-1:0] q_d [$];
  logic [P-1:0]  q_m [$];
  logic [GW-1:0] cur_d;
  logic [P-1:0]  cur_m;
  int            cur_n, dcnt;
  bit            mrdy, exp_rdy, acc, dlv;

  always @(posedge clk) begin
    if (!rst) begin
      q_d.delete(); q_m.delete();
      cur_d = '0; cur_m = '0; cur_n = 0; mrdy = 0;
    end else begin
      exp_rdy = mrdy && (q_d.size() < 2);
      acc     = s_valid && exp_rdy;
      dlv     = (q_d.size() > 0) && m_ready;
      if (dlv) begin
        void'(q_d.pop_front()); void'(q_m.pop_front()); dcnt++;
      end
      if (acc) begin
        cur_d[cur_n*DW +: DW] = s_data;
        cur_m[cur_n] = 1'b1;
        cur_n++;
        if (cur_n == P || s_last) begin
          q_d.push_back(cur_d); q_m.push_back(cur_m);
          cur_d = '0; cur_m = '0; cur_n = 0;
        end
      end
      mrdy = 1;
    end
  end

  logic [GW-1:0] dlog [$];
  logic [P-1:0]  mlog [$];

  always @(negedge clk) begin
    if (!rst) begin
      chk("reset_outputs", {s_ready, m_valid, en, lane_mask, flat}, '0);
    end else begin
      chk("s_ready", s_ready, mrdy && (q_d.size() < 2));
      chk("m_valid", m_valid, q_d.size() > 0);
      chk("en", en, (q_d.size() > 0) && m_ready);
      if (q_d.size() > 0) begin
        chk("data_out", flat, q_d[0]);
        chk("lane_mask", lane_mask, q_m[0]);
      end
`ifdef PACKER_GRP_CNT_EN
      chk("grp_cnt", grp_cnt, dcnt[15:0]);
      chk("short_grp", short_grp, (q_d.size() > 0) && (q_m[0] != {P{1'b1}}));
`endif
      if (en) begin
        dlog.push_back(flat);
        mlog.push_back(lane_mask);
      end
    end
  end

  // Inputs change 2 time units after the rising edge; outputs are sampled on the falling edge
  task automatic beat(input logic [DW-1:0] d, input logic l);
    bit ok;
    int n;
    ok = 0; n = 0;
    s_valid = 1'b1; s_data = d; s_last = l;
    while (!ok && n < 200) begin
      @(negedge clk);
      ok = s_ready;
      if (!ok) stalls++;
      @(posedge clk); #2;
      n++;
    end
    if (!ok) chk("beat_timeout", 0, 1);
    s_valid = 1'b0; s_last = 1'b0;
  endtask

  task automatic wait_log(input int n);
    int c;
    c = 0;
    while (dlog.size() < n && c < 200) begin
      @(posedge clk); #2;
      c++;
    end
    if (dlog.size() < n) chk("deliver_timeout", dlog.size(), n);
  endtask

  task automatic do_reset();
    rst = 1'b0; s_valid = 1'b0; s_last = 1'b0; s_data = '0;
    repeat (3) @(posedge clk);
    #2 rst = 1'b1;
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #2; end
  endtask

  initial begin
    rst = 1'b0; s_valid = 1'b0; s_last = 1'b0; s_data = '0; m_ready = 1'b0;
    dcnt = 0;
    do_reset();

    // Back-to-back full groups
    m_ready = 1'b1;
    dlog.delete(); mlog.delete();
    for (int k = 1; k <= 8; k++) beat(DW'(k), 1'b0);
    wait_log(2);
    chk("grp1_data", dlog[0], 16'h4321); chk("grp1_mask", mlog[0], 4'hF);
    chk("grp2_data", dlog[1], 16'h8765); chk("grp2_mask", mlog[1], 4'hF);

    // Early close via s_last, then a group starting back at lane 0
    dlog.delete(); mlog.delete();
    beat(4'd9, 1'b0); beat(4'd10, 1'b1);
    for (int k = 11; k <= 14; k++) beat(DW'(k), 1'b0);
    wait_log(2);
    chk("short_data", dlog[0], 16'h00A9); chk("short_mask", mlog[0], 4'h3);
    chk("lane0_data", dlog[1], 16'hEDCB); chk("lane0_mask", mlog[1], 4'hF);

    // Backpressure: two groups held, input stalls
    idle(2);
    m_ready = 1'b0;
    dlog.delete(); mlog.delete();
    for (int k = 1; k <= 8; k++) beat(DW'(k), 1'b0);
    s_valid = 1'b1; s_data = 4'd9;
    repeat (4) begin
      @(negedge clk);
      chk("wait_s_ready", s_ready, 1'b0);
      chk("wait_hold", flat, 16'h4321);
      @(posedge clk); #2;
    end
    m_ready = 1'b1;
    for (int k = 9; k <= 12; k++) beat(DW'(k), 1'b0);
    wait_log(3);
    chk("bp_g1", dlog[0], 16'h4321);
    chk("bp_g2", dlog[1], 16'h8765);
    chk("bp_g3", dlog[2], 16'hCBA9);
    chk("bp_count", dlog.size(), 3);

    // Drain and load on the same edge
    idle(2);
    m_ready = 1'b0;
    dlog.delete(); mlog.delete();
    stalls = 0;
    for (int k = 1; k <= 7; k++) beat(DW'(k), 1'b0);
    m_ready = 1'b1;
    beat(4'd8, 1'b0);
    m_ready = 1'b0;
    @(negedge clk);
    chk("swap_en_count", dlog.size(), 1);
    chk("swap_next", flat, 16'h8765);
    chk("swap_valid", m_valid, 1'b1);
    @(posedge clk); #2;
    m_ready = 1'b1;
    wait_log(2);
    chk("swap_g1", dlog[0], 16'h4321);
    chk("swap_g2", dlog[1], 16'h8765);
    chk("swap_no_stall", stalls, 0);

    // Reset mid-group
    idle(2);
    dlog.delete(); mlog.delete();
    beat(4'd1, 1'b0); beat(4'd2, 1'b0);
    do_reset();
    for (int k = 5; k <= 8; k++) beat(DW'(k), 1'b0);
    wait_log(1);
    chk("rst_g1", dlog[0], 16'h8765);
    chk("rst_m1", mlog[0], 4'hF);

    // Randomized traffic with varying backpressure
    for (int ph = 0; ph < 6; ph++) begin
      int rp;
      rp = 20 + ph * 15;
      for (int c = 0; c < 500; c++) begin
        s_valid = ($urandom_range(0, 99) < 75);
        s_data  = DW'($urandom);
        s_last  = ($urandom_range(0, 9) == 0);
        m_ready = ($urandom_range(0, 99) < rp);
        @(posedge clk); #2;
      end
    end
    s_valid = 1'b0; s_last = 1'b0; m_ready = 1'b1;
    idle(10);
    chk("drained", m_valid, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
